// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: turns one execute-stage memory request into an AXI-lite style
// read (AR/R) or write (AW+W/B) transaction and reports completion to writeback.
module ysyx_22041211_lsu #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_req_i,
  input  logic [3:0]          mem_op_i,
  input  logic [DATA_LEN-1:0] addr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  output logic [DATA_LEN-1:0] araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_LEN-1:0] rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [DATA_LEN-1:0] awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_LEN-1:0] wdata,
  output logic [3:0]          wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                lsu_valid,
  output logic [DATA_LEN-1:0] rdata_o,
  output logic                lsu_err,
  output logic                lsu_busy
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

  // Store/load direction is consumed at latch time, so only unsigned+size persist.
  typedef struct packed {
    logic [2:0]          op;
    logic [DATA_LEN-1:0] addr;
    logic [DATA_LEN-1:0] wdata;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic   aw_done_q, w_done_q;
  logic   fault_in;
  logic [1:0]          off;
  logic [DATA_LEN-1:0] tmp, load_ext;

  assign fault_in = (mem_op_i[1:0] == 2'b11) ||
                    (mem_op_i[1:0] == 2'b01 && addr_i[0]) ||
                    (mem_op_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);

  assign off = req_q.addr[1:0];
  assign tmp = rdata >> {off, 3'b000};

  always_comb begin
    load_ext = tmp;
    case (req_q.op[1:0])
      2'b00:   load_ext = req_q.op[2] ? {{(DATA_LEN-8){1'b0}}, tmp[7:0]}
                                      : {{(DATA_LEN-8){tmp[7]}}, tmp[7:0]};
      2'b01:   load_ext = req_q.op[2] ? {{(DATA_LEN-16){1'b0}}, tmp[15:0]}
                                      : {{(DATA_LEN-16){tmp[15]}}, tmp[15:0]};
      default: load_ext = tmp;
    endcase
  end

  always_comb begin
    wstrb = 4'b1111;
    case (req_q.op[1:0])
      2'b00:   wstrb = 4'b0001 << off;
      2'b01:   wstrb = 4'b0011 << off;
      default: wstrb = 4'b1111;
    endcase
  end

  assign araddr    = {req_q.addr[DATA_LEN-1:2], 2'b00};
  assign awaddr    = {req_q.addr[DATA_LEN-1:2], 2'b00};
  assign wdata     = req_q.wdata << {off, 3'b000};
  assign arvalid   = (state_q == AR);
  assign rready    = (state_q == R);
  assign awvalid   = (state_q == AW_W) && !aw_done_q;
  assign wvalid    = (state_q == AW_W) && !w_done_q;
  assign bready    = (state_q == B);
  assign lsu_valid = (state_q == DONE);
  assign lsu_busy  = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_req_i) state_d = fault_in ? DONE : (mem_op_i[3] ? AW_W : AR);
      AR:   if (arready) state_d = R;
      R:    if (rvalid) state_d = DONE;
      // Either handshake may have finished in an earlier cycle or finish now.
      AW_W: if ((aw_done_q || awready) && (w_done_q || wready)) state_d = B;
      B:    if (bvalid) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_o   <= '0;
      lsu_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (mem_req_i) begin
          req_q     <= '{op: mem_op_i[2:0], addr: addr_i, wdata: wdata_i};
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          rdata_o   <= '0;
          lsu_err   <= fault_in;
        end
        AW_W: begin
          if (awready) aw_done_q <= 1'b1;
          if (wready)  w_done_q  <= 1'b1;
        end
        R: if (rvalid) begin
          rdata_o <= load_ext;
          lsu_err <= (rresp != 2'b00);
        end
        B: if (bvalid) lsu_err <= (bresp != 2'b00);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Directed bench for the LSU: vector table with a delay-programmable bus responder,
// plus hand-written reset sequences.
module tb_ysyx_22041211_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_i;
  logic [3:0]  mem_op_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        lsu_valid;
  logic [31:0] rdata_o;
  logic        lsu_err, lsu_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22041211_lsu #(.DATA_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req_i(mem_req_i), .mem_op_i(mem_op_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .lsu_valid(lsu_valid), .rdata_o(rdata_o), .lsu_err(lsu_err), .lsu_busy(lsu_busy)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr, wd, rd;
    logic [1:0]  rr, br;
    int          ard, rdd, awd, wdd, bd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          lat, n_ar, n_r, n_aw, n_w, n_b;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic outs_zero();
    return ({arvalid, rready, awvalid, wvalid, bready, lsu_valid, lsu_err, lsu_busy} == 8'd0)
           && (rdata_o == 32'd0);
  endfunction

  task automatic bus_idle();
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rdata = 0; rresp = 0; bresp = 0;
  endtask

  // Called right after a negedge; the request is sampled at the next posedge.
  task automatic run_vec(input vec_t v);
    int n = 0, c_ar = 0, c_r = 0, c_aw = 0, c_w = 0, c_b = 0, bad = 0;
    bit done = 0;
    mem_req_i = 1; mem_op_i = v.op; addr_i = v.addr; wdata_i = v.wd;
    rdata = v.rd; rresp = v.rr; bresp = v.br;
    @(posedge clk);
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      if (arvalid) begin
        if (araddr !== {v.addr[31:2], 2'b00}) bad++;
        arready = (c_ar >= v.ard); c_ar++;
      end
      if (rready) begin rvalid = (c_r >= v.rdd); c_r++; end
      if (awvalid) begin
        if (awaddr !== {v.addr[31:2], 2'b00}) bad++;
        awready = (c_aw >= v.awd); c_aw++;
      end
      if (wvalid) begin
        if (wdata !== v.exp_wdata || wstrb !== v.exp_strb) bad++;
        wready = (c_w >= v.wdd); c_w++;
      end
      if (bready) begin bvalid = (c_b >= v.bd); c_b++; end
      if (lsu_valid) done = 1;
      // A faulting store request while busy must be ignored.
      mem_req_i = !done && lsu_busy;
      mem_op_i = 4'b1010; addr_i = 32'h0000_0002; wdata_i = 32'hFFFF_FFFF;
    end
    chk({v.name, " latency"}, done ? n : -1, v.lat);
    chk({v.name, " rdata_o"}, rdata_o, v.exp_rdata);
    chk({v.name, " lsu_err"}, {31'd0, lsu_err}, {31'd0, v.exp_err});
    chk({v.name, " ar_cycles"}, c_ar, v.n_ar);
    chk({v.name, " r_cycles"}, c_r, v.n_r);
    chk({v.name, " aw_cycles"}, c_aw, v.n_aw);
    chk({v.name, " w_cycles"}, c_w, v.n_w);
    chk({v.name, " b_cycles"}, c_b, v.n_b);
    chk({v.name, " bus_values"}, bad, 0);
    mem_req_i = 0;
    bus_idle();
    @(negedge clk);
    chk({v.name, " post_valid_busy"}, {30'd0, lsu_valid, lsu_busy}, 32'd0);
    chk({v.name, " post_rdata_hold"}, rdata_o, v.exp_rdata);
    chk({v.name, " post_err_hold"}, {31'd0, lsu_err}, {31'd0, v.exp_err});
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] op, input logic [31:0] addr,
      input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] rr, input logic [1:0] br,
      input int ard, input int rdd, input int awd, input int wdd, input int bd,
      input logic [31:0] er, input logic ee, input logic [3:0] es, input logic [31:0] ew,
      input int lat, input int nar, input int nr, input int naw, input int nw, input int nb);
    vec_t v;
    v.name = nm; v.op = op; v.addr = addr; v.wd = wd; v.rd = rd; v.rr = rr; v.br = br;
    v.ard = ard; v.rdd = rdd; v.awd = awd; v.wdd = wdd; v.bd = bd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_strb = es; v.exp_wdata = ew;
    v.lat = lat; v.n_ar = nar; v.n_r = nr; v.n_aw = naw; v.n_w = nw; v.n_b = nb;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk("lb_neg",   4'b0000, 32'h8000_0003, 32'h0, 32'h8000_0000, 2'b00, 2'b00, 0,0,0,0,0,
                  32'hFFFF_FF80, 0, 4'h0, 32'h0, 3, 1,1,0,0,0);
    vecs[1]  = mk("lhu",      4'b0101, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 2'b00, 2'b00, 0,0,0,0,0,
                  32'h0000_BEEF, 0, 4'h0, 32'h0, 3, 1,1,0,0,0);
    vecs[2]  = mk("lh",       4'b0001, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 2'b00, 2'b00, 0,0,0,0,0,
                  32'hFFFF_BEEF, 0, 4'h0, 32'h0, 3, 1,1,0,0,0);
    vecs[3]  = mk("sb_awlate",4'b1000, 32'h8000_0001, 32'h0000_00AB, 32'h0, 2'b00, 2'b00, 0,0,2,0,0,
                  32'h0, 0, 4'b0010, 32'h0000_AB00, 5, 0,0,3,1,1);
    vecs[4]  = mk("sw_mis",   4'b1010, 32'h8000_0002, 32'h1111_1111, 32'h0, 2'b00, 2'b00, 0,0,0,0,0,
                  32'h0, 1, 4'h0, 32'h0, 1, 0,0,0,0,0);
    vecs[5]  = mk("lw_rerr",  4'b0010, 32'h8000_0010, 32'h0, 32'h1234_5678, 2'b10, 2'b00, 0,5,0,0,0,
                  32'h1234_5678, 1, 4'h0, 32'h0, 8, 1,6,0,0,0);
    vecs[6]  = mk("lbu",      4'b0100, 32'h8000_0001, 32'h0, 32'h1234_5678, 2'b00, 2'b00, 0,0,0,0,0,
                  32'h0000_0056, 0, 4'h0, 32'h0, 3, 1,1,0,0,0);
    vecs[7]  = mk("sh",       4'b1001, 32'h8000_0002, 32'h0000_1234, 32'h0, 2'b00, 2'b00, 0,0,0,0,0,
                  32'h0, 0, 4'b1100, 32'h1234_0000, 3, 0,0,1,1,1);
    vecs[8]  = mk("sw_berr",  4'b1010, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 2'b00, 2'b11, 0,0,0,3,2,
                  32'h0, 1, 4'b1111, 32'hDEAD_BEEF, 8, 0,0,1,4,3);
    vecs[9]  = mk("size11",   4'b0011, 32'h8000_0000, 32'h0, 32'h5555_5555, 2'b00, 2'b00, 0,0,0,0,0,
                  32'h0, 1, 4'h0, 32'h0, 1, 0,0,0,0,0);
    vecs[10] = mk("lh_mis",   4'b0001, 32'h8000_0001, 32'h0, 32'h5555_5555, 2'b00, 2'b00, 0,0,0,0,0,
                  32'h0, 1, 4'h0, 32'h0, 1, 0,0,0,0,0);
    vecs[11] = mk("lb_pos",   4'b0000, 32'h8000_0000, 32'h0, 32'h0000_007F, 2'b00, 2'b00, 0,0,0,0,0,
                  32'h0000_007F, 0, 4'h0, 32'h0, 3, 1,1,0,0,0);
    vecs[12] = mk("lw_arlate",4'b0010, 32'h8000_0100, 32'h0, 32'hCAFE_F00D, 2'b00, 2'b00, 2,0,0,0,0,
                  32'hCAFE_F00D, 0, 4'h0, 32'h0, 5, 3,1,0,0,0);

    rst_n = 0; mem_req_i = 0; mem_op_i = 0; addr_i = 0; wdata_i = 0;
    bus_idle();
    // Outputs must stay at reset values whatever the bus does.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {31'd0, outs_zero()}, 32'd1);
      arready = 1'($urandom); rvalid = 1'($urandom); awready = 1'($urandom);
      wready = 1'($urandom); bvalid = 1'($urandom); rdata = $urandom;
      mem_req_i = 1'($urandom); mem_op_i = 4'($urandom);
    end
    @(negedge clk);
    chk("reset_outputs", {31'd0, outs_zero()}, 32'd1);
    bus_idle(); mem_req_i = 0;
    rst_n = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting in R: rready must drop and no completion appear.
    mem_req_i = 1; mem_op_i = 4'b0010; addr_i = 32'h8000_0040;
    @(negedge clk);
    mem_req_i = 0;
    chk("midrst_arvalid", {31'd0, arvalid}, 32'd1);
    arready = 1;
    @(negedge clk);
    arready = 0;
    chk("midrst_rready", {31'd0, rready}, 32'd1);
    @(negedge clk);
    chk("midrst_rready_hold", {31'd0, rready}, 32'd1);
    rst_n = 0; rvalid = 1; rdata = 32'hA5A5_A5A5; arready = 1; awready = 1; wready = 1; bvalid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_outputs", {31'd0, outs_zero()}, 32'd1);
    end
    bus_idle();
    rst_n = 1;
    @(negedge clk);
    chk("midrst_no_valid", {30'd0, lsu_valid, lsu_busy}, 32'd0);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ysyx_22041211_lsu.md
YSYX_22041211_LSU -- requirements
Module: ysyx_22041211_lsu

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, the data/address width; only 32 is supported.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-005 SHALL have port mem_req_i, input, 1: execute stage requests a memory access.
REQ-006 SHALL have port mem_op_i, input, 4: bit3 store (1) or load (0); bit2 unsigned load; bits1:0 size (00 byte, 01 half, 10 word, 11 illegal).
REQ-007 SHALL have ports addr_i and wdata_i, input, DATA_LEN: effective address and store data (data in low bits).
REQ-008 SHALL have read-address ports araddr/arvalid (output, DATA_LEN/1) and arready (input, 1).
REQ-009 SHALL have read-data ports rdata (input, DATA_LEN), rresp (input, 2), rvalid (input, 1) and rready (output, 1).
REQ-010 SHALL have write ports awaddr/awvalid (output), awready (input), wdata (output, DATA_LEN), wstrb (output, 4), wvalid (output) and wready (input).
REQ-011 SHALL have write-response ports bresp (input, 2), bvalid (input, 1) and bready (output, 1).
REQ-012 SHALL have outputs lsu_valid (1, completion pulse to writeback), rdata_o (DATA_LEN, extended load data), lsu_err (1, fault with the pulse) and lsu_busy (1, state not IDLE).

Function
REQ-013 SHALL implement states IDLE, AR, R, AW_W, B and DONE.
REQ-014 In IDLE with mem_req_i=1, SHALL latch mem_op_i/addr_i/wdata_i and go to AR (load), AW_W (store) or DONE with fault.
- A fault is size 11, half with addr[0]=1, or word with addr[1:0]!=0.
REQ-015 SHALL ignore mem_req_i in every state except IDLE.
REQ-016 In AR, SHALL assert arvalid=1 and araddr={addr[31:2],2'b00}, and go to R on arready.
REQ-017 In R, SHALL assert rready=1; on rvalid, SHALL capture the extended data and go to DONE.
- lsu_err is set when rresp!=0.
REQ-018 In AW_W, SHALL drive awvalid and wvalid together; each drops individually once its ready is sampled high.
- SHALL go to B in the cycle both handshakes have completed, including the same cycle.
REQ-019 In B, SHALL assert bready=1; on bvalid, SHALL go to DONE with lsu_err=(bresp!=0).
REQ-020 In DONE, SHALL assert lsu_valid=1 for exactly one cycle, then return to IDLE.
- rdata_o and lsu_err SHALL hold until the next request is latched.
REQ-021 Each valid SHALL stay high, with address, data and strobe stable, until its handshake completes; it is never withdrawn.
REQ-022 Store strobe by size (off=addr[1:0]): byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
- wdata SHALL be wdata_i<<(8*off).
REQ-023 Load extraction SHALL be tmp=rdata>>(8*off), then sign- or zero-extend (per bit2) the low 8/16 bits; a word load passes tmp unchanged.
REQ-024 On a faulted request, SHALL issue no bus valid, set lsu_err=1 and rdata_o=0.
REQ-025 Minimum latency with zero-wait bus SHALL be 3 cycles from the request cycle to lsu_valid, for both loads and stores.
REQ-026 SHALL accept a new request in the cycle following DONE at the earliest.

Reset
REQ-027 While rst_n=0 at a clock edge, SHALL enter IDLE and drive arvalid, rready, awvalid, wvalid, bready, lsu_valid, lsu_err, lsu_busy=0 and rdata_o=0.
REQ-028 Reset mid-transaction SHALL drop all valids the following cycle without waiting for responses.
- No lsu_valid is produced for the aborted access.
REQ-029 SHALL hold all outputs at reset values for as long as rst_n=0, regardless of bus inputs.

Verification
REQ-030 LB, addr=0x8000_0003, rdata=0x8000_0000, zero-wait -> araddr=0x8000_0000; rdata_o=0xFFFF_FF80; lsu_valid 3 cycles after the request.
REQ-031 LHU, addr=0x...2, rdata=0xBEEF_1234 -> rdata_o=0x0000_BEEF; same access as LH -> 0xFFFF_BEEF.
REQ-032 SB, addr=0x...1, wdata_i=0xAB; awready 2 cycles late, wready immediate -> wstrb=4'b0010, wdata=0x0000_AB00; wvalid drops after 1 cycle, awvalid holds until awready; single lsu_valid.
REQ-033 SW, addr=0x...2 -> no arvalid or awvalid; lsu_err=1 and lsu_valid 1 cycle after the request.
REQ-034 LW, rvalid delayed 5 cycles, rresp=2'b10 -> rready held high throughout; lsu_valid with lsu_err=1.
REQ-035 rst_n=0 while in R -> rready=0 and state IDLE next cycle; no lsu_valid; a request 1 cycle after release completes normally.
